mc_ctrl_fsm: RTL

// Multi-cycle sequencer for the RV32I datapath: IF/ID/EX/MEM/WB state machine driving PC, IR, RF and data-memory strobes.

---
 rtl/mc_ctrl_fsm_pkg.sv | 72 +++++++
 rtl/mc_ctrl_fsm_mem_wait_timer.sv | 32 +++
 rtl/mc_ctrl_fsm.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/mc_ctrl_fsm_pkg.sv
// Shared encodings for the RV32I multi-cycle sequencer: states, opcodes, mux selects,
// fault codes, and the opcode-class / branch-resolution helpers.
package mc_ctrl_fsm_pkg;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_TRAP = 3'd5
  } state_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  localparam logic [2:0] NPC_PLUS4  = 3'b000;
  localparam logic [2:0] NPC_BRANCH = 3'b001;
  localparam logic [2:0] NPC_JUMP   = 3'b010;
  localparam logic [2:0] NPC_JALR   = 3'b100;

  localparam logic [1:0] WD_ALU = 2'b00;
  localparam logic [1:0] WD_MEM = 2'b01;
  localparam logic [1:0] WD_PC4 = 2'b10;

  localparam logic [1:0] FLT_NONE    = 2'b00;
  localparam logic [1:0] FLT_ILLEGAL = 2'b01;
  localparam logic [1:0] FLT_IMEM    = 2'b10;
  localparam logic [1:0] FLT_DMEM    = 2'b11;

  typedef struct packed {
    logic r;
    logic i;
    logic load;
    logic store;
    logic br;
    logic jal;
    logic jalr;
    logic lui;
  } op_class_t;

  // All-zero result marks an opcode the datapath cannot execute.
  function automatic op_class_t classify(input logic [6:0] op);
    op_class_t c;
    c = '0;
    case (op)
      OP_R:     c.r     = 1'b1;
      OP_I:     c.i     = 1'b1;
      OP_LOAD:  c.load  = 1'b1;
      OP_STORE: c.store = 1'b1;
      OP_BR:    c.br    = 1'b1;
      OP_JAL:   c.jal   = 1'b1;
      OP_JALR:  c.jalr  = 1'b1;
      OP_LUI:   c.lui   = 1'b1;
      default:  c     = '0;
    endcase
    return c;
  endfunction

  // funct3[2] picks the less-than compare over equality; funct3[0] inverts the sense.
  function automatic logic branch_taken(input logic [2:0] f3, input logic zero,
                                        input logic lt);
    return f3[2] ? (lt ^ f3[0]) : (zero ^ f3[0]);
  endfunction

endpackage

// File: rtl/mc_ctrl_fsm_mem_wait_timer.sv
// Counts cycles spent waiting on a memory ack and flags expiry on the last allowed
// cycle; an ack arriving in that same cycle suppresses expiry.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rstn,
  input  logic clear,
  input  logic tick,
  input  logic ack,
  output logic expired
);

  localparam bit EN = (MEM_TIMEOUT != 0);
  localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TW-1:0] LAST = TW'(EN ? MEM_TIMEOUT - 1 : 0);

  logic [TW-1:0] cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (clear || ack || !EN) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= cnt + TW'(1);
    end
  end

  assign expired = EN && tick && !ack && (cnt == LAST);

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle IF/ID/EX/MEM/WB sequencer for the RV32I datapath: memory handshakes with
// timeout, branch resolution, retired-instruction count and illegal-opcode trap.
module mc_ctrl_fsm
  import mc_ctrl_fsm_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             run,
  input  logic [6:0]       Op,
  input  logic [2:0]       Funct3,
  input  logic             Zero,
  input  logic             alu_lt,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  output logic             imem_req,
  output logic             ir_we,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             rf_we,
  output logic [1:0]       wd_sel,
  output logic             pc_we,
  output logic [2:0]       npc_sel,
  output logic             halted,
  output logic [1:0]       fault_code,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] instret_cnt
);

  state_t     state, next_state;
  op_class_t  cls;
  logic [1:0] fault_nxt;
  logic       if_pend;
  logic       fetch;
  logic       wait_tick;
  logic       expired;
  logic       br_bad;
  logic       taken;

  // Once a fetch is issued it stays requested until ack, even if run drops.
  assign fetch     = rstn && (run || if_pend);
  assign wait_tick = imem_req || dmem_req;
  assign br_bad    = (Funct3[2:1] == 2'b01);
  assign taken     = branch_taken(Funct3, Zero, alu_lt);
  assign state_o   = state;

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk     (clk),
    .rstn    (rstn),
    .clear   (!wait_tick),
    .tick    (wait_tick),
    .ack     (state == S_IF ? imem_ack : dmem_ack),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IF;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    fault_nxt  = fault_code;
    case (state)
      S_IF: begin
        if (imem_req && imem_ack) begin
          next_state = S_ID;
        end else if (expired) begin
          next_state = S_TRAP;
          fault_nxt  = FLT_IMEM;
        end
      end
      S_ID: begin
        if (classify(Op) == '0) begin
          next_state = S_TRAP;
          fault_nxt  = FLT_ILLEGAL;
        end else begin
          next_state = S_EX;
        end
      end
      S_EX: begin
        if (cls.br && br_bad) begin
          next_state = S_TRAP;
          fault_nxt  = FLT_ILLEGAL;
        end else if (cls.br) begin
          next_state = S_IF;
        end else if (cls.load || cls.store) begin
          next_state = S_MEM;
        end else begin
          next_state = S_WB;
        end
      end
      S_MEM: begin
        if (dmem_ack) begin
          next_state = cls.store ? S_IF : S_WB;
        end else if (expired) begin
          next_state = S_TRAP;
          fault_nxt  = FLT_DMEM;
        end
      end
      S_WB:    next_state = S_IF;
      S_TRAP:  next_state = S_TRAP;
      default: next_state = S_IF;
    endcase
  end

  always_comb begin
    imem_req = 1'b0;
    ir_we    = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    rf_we    = 1'b0;
    wd_sel   = WD_ALU;
    pc_we    = 1'b0;
    npc_sel  = NPC_PLUS4;
    halted   = 1'b0;
    case (state)
      S_IF: begin
        imem_req = fetch;
        ir_we    = fetch && imem_ack;
      end
      S_EX: begin
        if (cls.br && !br_bad) begin
          pc_we   = 1'b1;
          npc_sel = taken ? NPC_BRANCH : NPC_PLUS4;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = cls.store;
        pc_we    = cls.store && dmem_ack;
      end
      S_WB: begin
        rf_we   = 1'b1;
        pc_we   = 1'b1;
        wd_sel  = cls.load ? WD_MEM : ((cls.jal || cls.jalr) ? WD_PC4 : WD_ALU);
        npc_sel = cls.jal ? NPC_JUMP : (cls.jalr ? NPC_JALR : NPC_PLUS4);
      end
      S_TRAP:  halted = 1'b1;
      default: halted = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cls         <= '0;
      fault_code  <= FLT_NONE;
      if_pend     <= 1'b0;
      instret_cnt <= '0;
    end else begin
      fault_code <= fault_nxt;
      if_pend    <= (state == S_IF) && imem_req && !imem_ack;
      if (state == S_ID) cls <= classify(Op);
      if (pc_we) instret_cnt <= instret_cnt + CNT_W'(1);
    end
  end

endmodule
